pifo_reg_ctrl: RTL and testbench
================================

Name: pifo_reg_ctrl

Overview:
Sequencing and arbitration front-end for a single pifo_reg instance in the PIFO datapath.
- Arbitrates two enqueue sources (round-robin) and one dequeue sink onto the register's insert/remove pins.
- Enforces the register's post-operation settle time.
- Presents the head entry as a valid/ready stream.
- Reports every entry lost when inserting into a full register.
- Sits between the packet classifier/rank computation and the output scheduler.

Parameters:
L2_REG_WIDTH, 4, log2 of the pifo_reg depth (capacity 2**L2_REG_WIDTH).
RANK_WIDTH, 16, rank field width.
META_WIDTH, 12, metadata field width.
SETTLE_CYCLES, 2, idle cycles after each issued op before the next op is issued (minimum 2).

Ports:
clk  in  1  single clock domain.
rst_n  in  1  asynchronous, active-low reset.
enq0_valid / enq1_valid  in  1  enqueue requests from source 0 / 1.
enq0_ready / enq1_ready  out  1  grant; the transfer occurs when valid&ready.
enq0_rank / enq1_rank  in  RANK_WIDTH  rank of the request.
enq0_meta / enq1_meta  in  META_WIDTH  metadata of the request.
deq_valid  out  1  head entry available.
deq_ready  in  1  sink accepts the head.
deq_rank  out  RANK_WIDTH  head rank.
deq_meta  out  META_WIDTH  head metadata.
drop_valid  out  1  one-cycle pulse: an entry was discarded.
drop_evicted  out  1  1 = a resident max entry was evicted; 0 = the incoming entry was rejected.
drop_rank  out  RANK_WIDTH  rank of the discarded entry.
drop_meta  out  META_WIDTH  metadata of the discarded entry.
drop_count  out  32  saturating count of discards.
pf_insert  out  1  to pifo_reg insert.
pf_rank_in  out  RANK_WIDTH  to pifo_reg rank_in.
pf_meta_in  out  META_WIDTH  to pifo_reg meta_in.
pf_remove  out  1  to pifo_reg remove.
pf_valid_out  in  1  from pifo_reg valid_out.
pf_rank_out  in  RANK_WIDTH  from pifo_reg rank_out (min).
pf_meta_out  in  META_WIDTH  from pifo_reg meta_out (min).
pf_max_rank  in  RANK_WIDTH  from pifo_reg max_rank_out.
pf_max_meta  in  META_WIDTH  from pifo_reg max_meta_out.
pf_num_entries  in  L2_REG_WIDTH+1  from pifo_reg num_entries.

Behaviour:
- Reset: every output is 0; state = SETTLE with counter = SETTLE_CYCLES-1. No op is issued until at least SETTLE_CYCLES cycles after rst_n deasserts.
- The pifo_reg reset (active-high) is driven from ~rst_n at top level. The controller never relies on the pifo_reg empty/full outputs; it uses pf_num_entries only.

States:
- IDLE: the register is settled.
  - At most one op is issued per visit, combinationally from the current inputs; on issue, go to SETTLE.
- SETTLE: a down-counter runs for SETTLE_CYCLES cycles.
  - All readies are 0, deq_valid = 0, pf_insert = pf_remove = 0.
  - When the counter reaches 0, go to IDLE.

Dequeue and enqueue signalling:
- deq_valid = IDLE & pf_valid_out & (pf_num_entries != 0).
- deq_rank/deq_meta are pf_rank_out/pf_meta_out, passed through.
- Dequeue fires on deq_valid & deq_ready: pf_remove = 1 for that cycle.
- Enqueue is eligible in IDLE when either enqN_valid is high. The granted source gets enqN_ready = 1; pf_insert = 1 with that source's rank/meta.

Arbitration:
- Sources 0 and 1 are arbitrated round-robin. A last_enq pointer flips only on a granted enqueue; at reset it points to source 1, so source 0 goes first.
- If enqueue and dequeue are both eligible in IDLE, they alternate via a last_op flag (reset value = enqueue, so dequeue wins first).
- Exactly one of pf_insert / pf_remove is asserted per issue; both are never asserted together.

Full insert (pf_num_entries == 2**L2_REG_WIDTH):
- The insert is still issued.
- If new rank < pf_max_rank: register the max as dropped, with drop_evicted = 1 and drop_rank/meta = pf_max_rank/pf_max_meta.
- Otherwise: register the incoming entry as dropped, with drop_evicted = 0.
- drop_valid pulses in the cycle after issue.
- drop_count increments by 1 on each drop and saturates at 2**32-1.
- Equal ranks reject the incoming entry.

Other rules:
- An enqueue with no source valid, or a dequeue when pf_num_entries == 0, is never issued.
- Asynchronous reset in any state returns immediately to the reset values. Any in-flight drop pulse is cancelled.

Decomposition:
- Shared package pifo_pkg holds:
  - the state enum (IDLE, SETTLE);
  - RANK_WIDTH/META_WIDTH defaults;
  - the DROP_REJECT/DROP_EVICT encodings.
- One natural sub-module: rr_arb2, the two-requester round-robin arbiter with pointer update on grant.

Test Plan:
- Reset release, enq0 valid with rank 5 → no ready for 2 cycles; then enq0_ready for 1 cycle; pf_insert asserted; next grant no sooner than 2 cycles later.
- enq0 and enq1 held valid with ranks 7 and 3 → grants alternate 0,1,0,1. Draining gives deq_rank order 3,3,...,7,7.
- Fill 16 entries with ranks 10..25, then insert rank 4 → drop_valid=1, drop_evicted=1, drop_rank=25, drop_count=1. A later insert of rank 30 → drop_evicted=0, drop_rank=30, drop_count=2.
- Both directions pending with 4 entries, deq_ready=1, enq0 valid → ops alternate remove, insert, remove, insert, each separated by 2 settle cycles.
- Empty register, deq_ready=1 → deq_valid stays 0 and pf_remove is never asserted.
- Assert rst_n low during SETTLE right after a full insert → drop_valid stays 0; all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/pifo_pkg.sv
// pifo_pkg: shared types and encodings for the pifo_reg sequencing front-end
package pifo_pkg;
  typedef enum logic {IDLE, SETTLE} state_t;
  localparam int RANK_W = 16;
  localparam int META_W = 12;
  localparam logic DROP_REJECT = 1'b0;
  localparam logic DROP_EVICT = 1'b1;
endpackage

// File: rtl/pifo_reg_ctrl_if.sv
// pifo_reg_ctrl_if: enqueue/dequeue/drop streams plus the pifo_reg pin bundle
interface pifo_reg_ctrl_if #(
  parameter int L2_REG_WIDTH = 4,
  parameter int RANK_WIDTH = pifo_pkg::RANK_W,
  parameter int META_WIDTH = pifo_pkg::META_W
);
  logic enq0_valid, enq0_ready, enq1_valid, enq1_ready;
  logic deq_valid, deq_ready, drop_valid, drop_evicted;
  logic pf_insert, pf_remove, pf_valid_out;
  logic [RANK_WIDTH-1:0] enq0_rank, enq1_rank, deq_rank, drop_rank, pf_rank_in, pf_rank_out, pf_max_rank;
  logic [META_WIDTH-1:0] enq0_meta, enq1_meta, deq_meta, drop_meta, pf_meta_in, pf_meta_out, pf_max_meta;
  logic [31:0] drop_count;
  logic [L2_REG_WIDTH:0] pf_num_entries;
  modport slave (
    input enq0_valid, enq0_rank, enq0_meta, enq1_valid, enq1_rank, enq1_meta, deq_ready,
          pf_valid_out, pf_rank_out, pf_meta_out, pf_max_rank, pf_max_meta, pf_num_entries,
    output enq0_ready, enq1_ready, deq_valid, deq_rank, deq_meta, drop_valid, drop_evicted,
           drop_rank, drop_meta, drop_count, pf_insert, pf_rank_in, pf_meta_in, pf_remove
  );
  modport master (
    output enq0_valid, enq0_rank, enq0_meta, enq1_valid, enq1_rank, enq1_meta, deq_ready,
           pf_valid_out, pf_rank_out, pf_meta_out, pf_max_rank, pf_max_meta, pf_num_entries,
    input enq0_ready, enq1_ready, deq_valid, deq_rank, deq_meta, drop_valid, drop_evicted,
          drop_rank, drop_meta, drop_count, pf_insert, pf_rank_in, pf_meta_in, pf_remove
  );
endinterface

// File: rtl/pifo_reg_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, pointer moves only on an accepted grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last;
  always_comb begin
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & ~gnt[0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (en) last <= gnt[1];
endmodule

// File: rtl/pifo_reg_ctrl.sv
// pifo_reg_ctrl: arbitrates enqueues/dequeues onto one pifo_reg and enforces its settle time
module pifo_reg_ctrl import pifo_pkg::*; #(
  parameter int L2_REG_WIDTH = 4,
  parameter int RANK_WIDTH = RANK_W,
  parameter int META_WIDTH = META_W,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  pifo_reg_ctrl_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [L2_REG_WIDTH:0] CAP = (L2_REG_WIDTH+1)'(2**L2_REG_WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] gnt;
  logic last_enq_op, idle, has_entry, enq_req, deq_fire, do_rem, do_ins, issue, full, evict;
  logic [RANK_WIDTH-1:0] ins_rank;
  logic [META_WIDTH-1:0] ins_meta;
  rr_arb2 u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req({bus.enq1_valid, bus.enq0_valid}),
    .en(do_ins),
    .gnt(gnt)
  );
  always_comb begin
    idle = state == IDLE;
    has_entry = bus.pf_valid_out & (bus.pf_num_entries != '0);
    enq_req = bus.enq0_valid | bus.enq1_valid;
    deq_fire = idle & has_entry & bus.deq_ready;
    do_rem = deq_fire & (~enq_req | last_enq_op);
    do_ins = idle & enq_req & ~do_rem;
    issue = do_ins | do_rem;
    ins_rank = gnt[1] ? bus.enq1_rank : bus.enq0_rank;
    ins_meta = gnt[1] ? bus.enq1_meta : bus.enq0_meta;
    full = bus.pf_num_entries == CAP;
    evict = ins_rank < bus.pf_max_rank;
    state_nx = issue ? SETTLE : (state == SETTLE && cnt == '0) ? IDLE : state;
    cnt_nx = issue ? CW'(SETTLE_CYCLES-1) : (state == SETTLE && cnt != '0) ? cnt - 1'b1 : cnt;
  end
  assign bus.deq_valid = idle & has_entry;
  assign bus.deq_rank = bus.deq_valid ? bus.pf_rank_out : '0;
  assign bus.deq_meta = bus.deq_valid ? bus.pf_meta_out : '0;
  assign bus.enq0_ready = do_ins & gnt[0];
  assign bus.enq1_ready = do_ins & gnt[1];
  assign bus.pf_insert = do_ins;
  assign bus.pf_remove = do_rem;
  assign bus.pf_rank_in = do_ins ? ins_rank : '0;
  assign bus.pf_meta_in = do_ins ? ins_meta : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SETTLE;
      cnt <= CW'(SETTLE_CYCLES-1);
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_enq_op <= 1'b1;
      bus.drop_valid <= 1'b0;
      bus.drop_evicted <= DROP_REJECT;
      bus.drop_rank <= '0;
      bus.drop_meta <= '0;
      bus.drop_count <= '0;
    end else begin
      if (issue) last_enq_op <= do_ins;
      bus.drop_valid <= do_ins & full;
      if (do_ins && full) begin
        bus.drop_evicted <= evict ? DROP_EVICT : DROP_REJECT;
        bus.drop_rank <= evict ? bus.pf_max_rank : ins_rank;
        bus.drop_meta <= evict ? bus.pf_max_meta : ins_meta;
        if (bus.drop_count != '1) bus.drop_count <= bus.drop_count + 32'd1;
      end
    end
endmodule

// File: tb/tb_pifo_reg_ctrl.sv
// tb_pifo_reg_ctrl: table, directed and randomized checks against a queue-based pifo model
module tb_pifo_reg_ctrl;
  typedef struct { logic [15:0] r; logic [11:0] m; } ent_t;
  typedef struct { bit v0; logic [15:0] r0; bit v1; logic [15:0] r1; bit e0; bit e1; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  ent_t q[$];
  ent_t e;
  int k;
  vec_t tbl[18];
  always #5 clk = ~clk;
  pifo_reg_ctrl_if #(.L2_REG_WIDTH(4), .RANK_WIDTH(16), .META_WIDTH(12)) bus();
  pifo_reg_ctrl #(.L2_REG_WIDTH(4), .RANK_WIDTH(16), .META_WIDTH(12), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  // behavioural pifo_reg: sorted queue, stable among equal ranks
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (bus.pf_remove) begin
      if (q.size() > 0) void'(q.pop_front());
    end else if (bus.pf_insert) begin
      e = '{bus.pf_rank_in, bus.pf_meta_in};
      if (q.size() < 16 || e.r < q[$].r) begin
        if (q.size() == 16) void'(q.pop_back());
        k = 0;
        while (k < q.size() && q[k].r <= e.r) k++;
        q.insert(k, e);
      end
    end
    bus.pf_valid_out <= q.size() != 0;
    bus.pf_num_entries <= 5'(q.size());
    bus.pf_rank_out <= q.size() != 0 ? q[0].r : 16'd0;
    bus.pf_meta_out <= q.size() != 0 ? q[0].m : 12'd0;
    bus.pf_max_rank <= q.size() != 0 ? q[$].r : 16'd0;
    bus.pf_max_meta <= q.size() != 0 ? q[$].m : 12'd0;
  end
  function automatic logic [11:0] mk_meta(input logic [15:0] r);
    return r[11:0] ^ 12'hA5C;
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask
  task automatic step(input bit v0, input logic [15:0] r0, input bit v1, input logic [15:0] r1, input bit dr);
    @(negedge clk);
    bus.enq0_valid = v0; bus.enq0_rank = r0; bus.enq0_meta = mk_meta(r0);
    bus.enq1_valid = v1; bus.enq1_rank = r1; bus.enq1_meta = mk_meta(r1);
    bus.deq_ready = dr;
    #1;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_hs"}, {bus.enq0_ready, bus.enq1_ready, bus.deq_valid, bus.deq_rank, bus.deq_meta,
                      bus.pf_insert, bus.pf_remove, bus.pf_rank_in, bus.pf_meta_in}, 64'd0);
    chk({nm, "_drop"}, {bus.drop_valid, bus.drop_evicted, bus.drop_rank, bus.drop_meta, bus.drop_count}, 64'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.enq0_valid = 1'b1; bus.enq0_rank = 16'd9; bus.enq0_meta = 12'd1;
    bus.enq1_valid = 1'b1; bus.enq1_rank = 16'd8; bus.enq1_meta = 12'd2;
    bus.deq_ready = 1'b1;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic enq_one(input bit src, input logic [15:0] r);
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step(!src, r, src, r, 1'b0);
      got = src ? bus.enq1_ready : bus.enq0_ready;
    end
    if (!got) chk("enq_timeout", 64'd0, 64'd1);
  endtask
  task automatic chk_drop(input string nm, input bit ev, input logic [15:0] r, input int cnt);
    chk({nm, "_valid"}, bus.drop_valid, 64'd1);
    chk({nm, "_evicted"}, bus.drop_evicted, 64'(ev));
    chk({nm, "_rank"}, bus.drop_rank, 64'(r));
    chk({nm, "_meta"}, bus.drop_meta, 64'(mk_meta(r)));
    chk({nm, "_count"}, bus.drop_count, 64'(cnt));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
  initial begin
    logic [15:0] drain [6] = '{16'd3, 16'd3, 16'd5, 16'd5, 16'd7, 16'd7};
    int ops[4], at[4], n;
    for (int i = 0; i < 18; i++)
      tbl[i] = '{1'b1, (i < 6) ? 16'd5 : 16'd7, i >= 6, 16'd3,
                 i == 2 || i == 5 || i == 11 || i == 17, i == 8 || i == 14};
    // grant timing and round-robin after reset
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v0, tbl[i].r0, tbl[i].v1, tbl[i].r1, 1'b0);
      chk($sformatf("tbl%0d_rdy0", i), bus.enq0_ready, 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_rdy1", i), bus.enq1_ready, 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_ins", i), {bus.pf_insert, bus.pf_remove}, {62'd0, tbl[i].e0 | tbl[i].e1, 1'b0});
      if (tbl[i].e0 | tbl[i].e1)
        chk($sformatf("tbl%0d_rank_in", i), bus.pf_rank_in, 64'(tbl[i].e0 ? tbl[i].r0 : tbl[i].r1));
    end
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      step(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
      if (bus.pf_remove) begin
        chk($sformatf("drain%0d", n), bus.deq_rank, 64'(drain[n]));
        n++;
      end
    end
    chk("drain_count", 64'(n), 64'd6);
    // empty register never dequeues
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
      chk("empty_deq", {bus.deq_valid, bus.pf_remove}, 64'd0);
    end
    // full-register drops
    do_reset();
    for (int r = 10; r <= 25; r++) enq_one(1'b0, 16'(r));
    enq_one(1'b0, 16'd4);
    step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    chk_drop("evict", 1'b1, 16'd25, 1);
    step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    chk("drop_pulse", bus.drop_valid, 64'd0);
    enq_one(1'b0, 16'd30);
    step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    chk_drop("reject", 1'b0, 16'd30, 2);
    enq_one(1'b0, 16'd24);
    step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    chk_drop("equal", 1'b0, 16'd24, 3);
    // reset while settling after a full insert
    enq_one(1'b0, 16'd1);
    @(posedge clk);
    #1 chk("pre_rst_drop", bus.drop_valid, 64'd1);
    rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
      chk("post_rst_drop", {bus.drop_valid, bus.drop_count}, 64'd0);
    end
    // enqueue/dequeue alternation
    do_reset();
    for (int r = 1; r <= 4; r++) enq_one(1'b0, 16'(r));
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step(1'b1, 16'd9, 1'b0, 16'd0, 1'b1);
      if (bus.pf_insert | bus.pf_remove) begin
        ops[n] = bus.pf_insert ? 1 : 2;
        at[n] = i;
        n++;
      end
    end
    chk("alt_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_op%0d", i), 64'(ops[i]), (i % 2 == 0) ? 64'd2 : 64'd1);
    for (int i = 1; i < 4; i++) chk($sformatf("alt_gap%0d", i), 64'(at[i] - at[i-1]), 64'd3);
    // randomized run against reference rules
    do_reset();
    begin
      int idle_at = 2, dcnt = 0;
      bit lsrc = 1'b1, lenq = 1'b1, pend = 1'b0, pev = 1'b0;
      logic [15:0] prk = '0, r0, r1;
      bit v0, v1, dr, idle, ne, deq_ok, enq_ok, x_rem, x_ins, x_src;
      for (int c = 0; c < 3000; c++) begin
        v0 = $urandom_range(0, 99) < 45;
        v1 = $urandom_range(0, 99) < 45;
        r0 = 16'($urandom_range(0, 40));
        r1 = 16'($urandom_range(0, 40));
        dr = $urandom_range(0, 99) < 30;
        step(v0, r0, v1, r1, dr);
        idle = c >= idle_at;
        ne = bus.pf_num_entries != 0;
        deq_ok = idle && ne && dr;
        enq_ok = idle && (v0 || v1);
        x_rem = deq_ok && (!enq_ok || lenq);
        x_ins = enq_ok && !x_rem;
        x_src = (v0 && v1) ? !lsrc : v1;
        chk("rnd_ops", {bus.pf_insert, bus.pf_remove}, {62'd0, x_ins, x_rem});
        chk("rnd_rdy", {bus.enq0_ready, bus.enq1_ready}, {62'd0, x_ins && !x_src, x_ins && x_src});
        chk("rnd_deq_valid", bus.deq_valid, 64'(idle && ne));
        if (idle && ne) chk("rnd_deq_rank", {bus.deq_rank, bus.deq_meta}, {36'd0, bus.pf_rank_out, bus.pf_meta_out});
        if (x_ins) chk("rnd_rank_in", bus.pf_rank_in, 64'(x_src ? r1 : r0));
        chk("rnd_drop_valid", bus.drop_valid, 64'(pend));
        if (pend) chk("rnd_drop", {bus.drop_evicted, bus.drop_rank}, {47'd0, pev, prk});
        chk("rnd_drop_count", bus.drop_count, 64'(dcnt));
        pend = 1'b0;
        if (x_ins || x_rem) begin
          idle_at = c + 3;
          lenq = x_ins;
        end
        if (x_ins) begin
          lsrc = x_src;
          if (bus.pf_num_entries == 16) begin
            pend = 1'b1;
            pev = (x_src ? r1 : r0) < bus.pf_max_rank;
            prk = pev ? bus.pf_max_rank : (x_src ? r1 : r0);
            dcnt++;
          end
        end
      end
      chk("rnd_saw_drops", 64'(dcnt != 0), 64'd1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
